// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4-channel mux scan sequencer.
package mux_scan_pkg;

  localparam int NCH  = 4;
  localparam int SELW = 2;
  localparam int CNTW = 4;

  localparam logic [SELW-1:0] LAST_IDX = SELW'(NCH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE
  } state_t;

endpackage

// File: rtl/mux_scan_settle_cnt.sv
// Loadable down-counter with a zero flag; times the select settle interval.
module mux_scan_settle_cnt
  import mux_scan_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic [CNTW-1:0] i_load_val,
  input  logic            i_dec,
  output logic            o_zero
);

  logic [CNTW-1:0] r_cnt;

  // Load takes priority so a reload on the capture edge is never lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNTW'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans a 4-to-1 mux frame by frame and holds one capture per channel.
// Optional change-detect output o_chg is built when MUX_SCAN_CHG_DET_EN is defined.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int W      = 4,
  parameter int SETTLE = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_cont,
  input  logic [W-1:0] i_mux_f,
  output logic         o_sel_s1,
  output logic         o_sel_s0,
  output logic [W-1:0] o_ch0,
  output logic [W-1:0] o_ch1,
  output logic [W-1:0] o_ch2,
  output logic [W-1:0] o_ch3,
  output logic         o_sample_valid,
  output logic [1:0]   o_sample_ch,
  output logic         o_busy,
`ifdef MUX_SCAN_CHG_DET_EN
  output logic [3:0]   o_chg,
`endif
  output logic         o_done
);

  localparam logic [CNTW-1:0] RELOAD = CNTW'(SETTLE - 1);

  state_t            r_state;
  logic [SELW-1:0]   r_idx;
  logic [W-1:0]      r_ch [NCH];
  logic              r_sample_valid;
  logic [SELW-1:0]   r_sample_ch;
  logic              r_busy;
  logic              r_done;
`ifdef MUX_SCAN_CHG_DET_EN
  logic [NCH-1:0]    r_chg;
`endif

  logic              w_load;
  logic              w_dec;
  logic              w_zero;

  // Reload on accepted start and on every capture that continues scanning.
  assign w_load = ((r_state == ST_IDLE) && i_start) ||
                  ((r_state == ST_CAPTURE) && ((r_idx != LAST_IDX) || i_cont));
  assign w_dec  = (r_state == ST_SETTLE);

  mux_scan_settle_cnt u_settle_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (RELOAD),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_sample_valid <= 1'b0;
      r_sample_ch    <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      for (int i = 0; i < NCH; i++) r_ch[i] <= '0;
`ifdef MUX_SCAN_CHG_DET_EN
      r_chg          <= '0;
`endif
    end else begin
      r_sample_valid <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_SETTLE;
            r_idx   <= '0;
            r_busy  <= 1'b1;
`ifdef MUX_SCAN_CHG_DET_EN
            r_chg   <= '0;
`endif
          end
        end
        ST_SETTLE: begin
          if (w_zero) r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          r_ch[r_idx]    <= i_mux_f;
          r_sample_valid <= 1'b1;
          r_sample_ch    <= r_idx;
`ifdef MUX_SCAN_CHG_DET_EN
          r_chg[r_idx]   <= (i_mux_f != r_ch[r_idx]);
`endif
          if (r_idx != LAST_IDX) begin
            r_idx   <= r_idx + SELW'(1);
            r_state <= ST_SETTLE;
          end else begin
            r_done <= 1'b1;
            if (i_cont) begin
              r_idx   <= '0;
              r_state <= ST_SETTLE;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_sel_s1       = r_idx[1];
  assign o_sel_s0       = r_idx[0];
  assign o_ch0          = r_ch[0];
  assign o_ch1          = r_ch[1];
  assign o_ch2          = r_ch[2];
  assign o_ch3          = r_ch[3];
  assign o_sample_valid = r_sample_valid;
  assign o_sample_ch    = r_sample_ch;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
`ifdef MUX_SCAN_CHG_DET_EN
  assign o_chg          = r_chg;
`endif

endmodule
